// File: rtl/sync_fifo_flex_if.sv
// Handshake bundle for sync_fifo_flex: write side, read side, status.
// Carries parity_err only when SYNC_FIFO_FLEX_PARITY_EN is defined.
interface sync_fifo_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  afull;
  logic                  aempty;
  logic                  empty;
  logic [CNT_WIDTH-1:0]  data_cnt;
  logic                  overflow;
  logic                  underflow;
`ifdef SYNC_FIFO_FLEX_PARITY_EN
  logic                  parity_err;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, afull, aempty, empty,
    input  data_cnt, overflow, underflow, parity_err
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, afull, aempty, empty,
    output data_cnt, overflow, underflow, parity_err
  );
`else
  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, afull, aempty, empty,
    input  data_cnt, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, afull, aempty, empty,
    output data_cnt, overflow, underflow
  );
`endif
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO: any depth >= 2, standard or FWFT read, error pulses.
// Optional per-entry even parity with SYNC_FIFO_FLEX_PARITY_EN.
module sync_fifo_flex #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_AFULL  = FIFO_DEPTH - 1,
  parameter int FIFO_AEMPTY = 1,
  parameter int FWFT_MODE   = 0,
  parameter int CNT_WIDTH   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_flex_if.slave  bus
);

`ifdef SYNC_FIFO_FLEX_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(FIFO_DEPTH - 1);

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flex: FIFO_DEPTH must be >= 2");
  end
  if (FIFO_AFULL < 1 || FIFO_AFULL > FIFO_DEPTH) begin : g_bad_afull
    $error("sync_fifo_flex: FIFO_AFULL out of range");
  end
  if (FIFO_AEMPTY < 0 || FIFO_AEMPTY > FIFO_DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flex: FIFO_AEMPTY out of range");
  end

  logic [MEM_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf_q;
  logic                 unf_q;
  logic                 is_full;
  logic                 is_empty;
  logic                 wr_ok;
  logic                 rd_ok;
  logic [MEM_W-1:0]     entry_in;
  logic [MEM_W-1:0]     head;

  function automatic logic [PTR_W-1:0] inc(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign is_full  = (cnt == CNT_WIDTH'(FIFO_DEPTH));
  assign is_empty = (cnt == '0);
  assign wr_ok    = bus.wr_en & ~is_full;
  assign rd_ok    = bus.rd_en & ~is_empty;
  assign head     = mem[rd_ptr];

`ifdef SYNC_FIFO_FLEX_PARITY_EN
  assign entry_in = {^bus.wr_data, bus.wr_data};
`else
  assign entry_in = bus.wr_data;
`endif

  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.afull     = (cnt >= CNT_WIDTH'(FIFO_AFULL));
  assign bus.aempty    = (cnt <= CNT_WIDTH'(FIFO_AEMPTY));
  assign bus.data_cnt  = cnt;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

  // Storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= entry_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      ovf_q <= bus.wr_en & is_full;
      unf_q <= bus.rd_en & is_empty;
      if (wr_ok) begin
        wr_ptr <= inc(wr_ptr);
      end
      if (rd_ok) begin
        rd_ptr <= inc(rd_ptr);
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  if (FWFT_MODE != 0) begin : g_fwft
    // Head word is shown combinationally; zero while nothing is stored.
    assign bus.rd_valid = ~is_empty;
    assign bus.rd_data  = is_empty ? '0 : head[DATA_WIDTH-1:0];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_ok;
        if (rd_ok) begin
          rd_data_q <= head[DATA_WIDTH-1:0];
        end
      end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
  end

`ifdef SYNC_FIFO_FLEX_PARITY_EN
  logic par_q;

  // An intact entry XORs to zero, so any odd bit count flags an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= rd_ok & (^head);
    end
  end

  assign bus.parity_err = par_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: standard depth-8 and FWFT depth-5 instances.
// Queue-based reference model, per-cycle compare, directed + random.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sync_fifo_flex_if #(.DATA_WIDTH(4), .CNT_WIDTH(4)) ifa ();
  sync_fifo_flex_if #(.DATA_WIDTH(8), .CNT_WIDTH(3)) ifb ();

  sync_fifo_flex #(
    .DATA_WIDTH(4), .FIFO_DEPTH(8), .FIFO_AFULL(7),
    .FIFO_AEMPTY(1), .FWFT_MODE(0), .CNT_WIDTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  sync_fifo_flex #(
    .DATA_WIDTH(8), .FIFO_DEPTH(5), .FIFO_AFULL(4),
    .FIFO_AEMPTY(1), .FWFT_MODE(1), .CNT_WIDTH(3)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  logic [3:0] qa[$];
  logic [7:0] qb[$];
  logic       ea_vld;
  logic [3:0] ea_dat;
  logic       ea_ovf, ea_unf;
  logic       eb_ovf, eb_unf;
  logic       ea_par;
  logic       flip_pending;
  int         compared   = 0;
  int         mismatched = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("a_cnt",    ifa.data_cnt,  qa.size());
    check("a_full",   ifa.full,      qa.size() == 8);
    check("a_afull",  ifa.afull,     qa.size() >= 7);
    check("a_aempty", ifa.aempty,    qa.size() <= 1);
    check("a_empty",  ifa.empty,     qa.size() == 0);
    check("a_vld",    ifa.rd_valid,  ea_vld);
    check("a_data",   ifa.rd_data,   ea_dat);
    check("a_ovf",    ifa.overflow,  ea_ovf);
    check("a_unf",    ifa.underflow, ea_unf);
    check("b_cnt",    ifb.data_cnt,  qb.size());
    check("b_full",   ifb.full,      qb.size() == 5);
    check("b_afull",  ifb.afull,     qb.size() >= 4);
    check("b_aempty", ifb.aempty,    qb.size() <= 1);
    check("b_empty",  ifb.empty,     qb.size() == 0);
    check("b_vld",    ifb.rd_valid,  qb.size() != 0);
    if (qb.size() != 0) begin
      check("b_data", ifb.rd_data, qb[0]);
    end
    check("b_ovf",    ifb.overflow,  eb_ovf);
    check("b_unf",    ifb.underflow, eb_unf);
`ifdef SYNC_FIFO_FLEX_PARITY_EN
    check("a_par",    ifa.parity_err, ea_par);
    check("b_par",    ifb.parity_err, 1'b0);
`endif
  end

  task automatic model_clear();
    qa.delete();
    qb.delete();
    ea_vld = 1'b0;
    ea_dat = '0;
    ea_ovf = 1'b0;
    ea_unf = 1'b0;
    eb_ovf = 1'b0;
    eb_unf = 1'b0;
    ea_par = 1'b0;
    flip_pending = 1'b0;
  endtask

  task automatic cyc(input logic aw, input logic [3:0] ad,
                     input logic ar, input logic bw,
                     input logic [7:0] bd, input logic br);
    logic a_full, b_full;
    ifa.wr_en = aw; ifa.wr_data = ad; ifa.rd_en = ar;
    ifb.wr_en = bw; ifb.wr_data = bd; ifb.rd_en = br;
    @(posedge clk);
    a_full = (qa.size() == 8);
    ea_ovf = aw && a_full;
    ea_unf = ar && qa.size() == 0;
    ea_vld = 1'b0;
    ea_par = 1'b0;
    if (ar && qa.size() != 0) begin
      ea_dat = qa.pop_front();
      ea_vld = 1'b1;
      ea_par = flip_pending;
      flip_pending = 1'b0;
    end
    if (aw && !a_full) qa.push_back(ad);
    b_full = (qb.size() == 5);
    eb_ovf = bw && b_full;
    eb_unf = br && qb.size() == 0;
    if (br && qb.size() != 0) void'(qb.pop_front());
    if (bw && !b_full) qb.push_back(bd);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    ifa.wr_en = 1'b0; ifa.rd_en = 1'b0;
    ifb.wr_en = 1'b0; ifb.rd_en = 1'b0;
    model_clear();
    #1;
    check("rst_a_cnt",   ifa.data_cnt,  0);
    check("rst_a_empty", ifa.empty,     1);
    check("rst_a_aemp",  ifa.aempty,    1);
    check("rst_a_full",  ifa.full,      0);
    check("rst_a_afull", ifa.afull,     0);
    check("rst_a_vld",   ifa.rd_valid,  0);
    check("rst_a_data",  ifa.rd_data,   0);
    check("rst_a_ovf",   ifa.overflow,  0);
    check("rst_a_unf",   ifa.underflow, 0);
    check("rst_b_cnt",   ifb.data_cnt,  0);
    check("rst_b_vld",   ifb.rd_valid,  0);
    check("rst_b_data",  ifb.rd_data,   0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  logic [3:0] drain [7];
  int         pw, pr;

  initial begin
    rst = 1'b1;
    ifa.wr_en = 1'b0; ifa.wr_data = '0; ifa.rd_en = 1'b0;
    ifb.wr_en = 1'b0; ifb.wr_data = '0; ifb.rd_en = 1'b0;
    model_clear();
    drain = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 4'(13 + i), 1'b0, 1'b0, '0, 1'b0);
      if (i == 6) begin
        check("fill_afull7", ifa.afull, 1);
        check("fill_full7",  ifa.full,  0);
      end
    end
    check("fill_full8", ifa.full,     1);
    check("fill_cnt8",  ifa.data_cnt, 8);
    cyc(1'b1, 4'h5, 1'b0, 1'b0, '0, 1'b0);
    check("ovf_pulse", ifa.overflow, 1);
    check("ovf_cnt",   ifa.data_cnt, 8);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    check("ovf_drop",  ifa.overflow, 0);
    cyc(1'b1, 4'h9, 1'b1, 1'b0, '0, 1'b0);
    check("fullrw_ovf",  ifa.overflow, 1);
    check("fullrw_data", ifa.rd_data,  4'hD);
    check("fullrw_cnt",  ifa.data_cnt, 7);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      check("drain_data", ifa.rd_data, drain[k]);
    end
    check("drain_empty", ifa.empty, 1);
    cyc(1'b1, 4'h6, 1'b1, 1'b0, '0, 1'b0);
    check("emprw_unf", ifa.underflow, 1);
    check("emprw_cnt", ifa.data_cnt,  1);
    check("emprw_vld", ifa.rd_valid,  0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("emprw_data", ifa.rd_data, 4'h6);

    for (int i = 1; i <= 5; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("mid_cnt4", ifa.data_cnt, 4);
    do_reset();
    cyc(1'b1, 4'h3, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("post_rst_vld",  ifa.rd_valid, 1);
    check("post_rst_data", ifa.rd_data,  4'h3);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++)
        cyc(1'b0, '0, 1'b0, 1'b1, 8'(r * 16 + i), 1'b0);
      check("wrap_full", ifb.full,     1);
      check("wrap_cnt5", ifb.data_cnt, 5);
      for (int i = 0; i < 5; i++) begin
        check("wrap_head", ifb.rd_data, 8'(r * 16 + i));
        cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      end
      check("wrap_empty", ifb.empty,    1);
      check("wrap_cnt0",  ifb.data_cnt, 0);
    end
    cyc(1'b0, '0, 1'b0, 1'b1, 8'h0A, 1'b0);
    check("fwft_vld",   ifb.rd_valid, 1);
    check("fwft_first", ifb.rd_data,  8'h0A);
    cyc(1'b0, '0, 1'b0, 1'b1, 8'h0B, 1'b0);
    check("fwft_hold",  ifb.rd_data,  8'h0A);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("fwft_next",  ifb.rd_data,  8'h0B);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("fwft_unf",   ifb.underflow, 1);

    for (int ph = 0; ph < 4; ph++) begin
      pw = (ph % 2 == 0) ? 75 : 30;
      pr = (ph % 2 == 0) ? 35 : 70;
      for (int n = 0; n < 250; n++) begin
        cyc($urandom_range(0, 99) < pw, 4'($urandom),
            $urandom_range(0, 99) < pr,
            $urandom_range(0, 99) < pw, 8'($urandom),
            $urandom_range(0, 99) < pr);
      end
    end

`ifdef SYNC_FIFO_FLEX_PARITY_EN
    do_reset();
    cyc(1'b1, 4'h7, 1'b0, 1'b0, '0, 1'b0);
    dut_a.mem[0][4] = ~dut_a.mem[0][4];
    flip_pending = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("par_flip", ifa.parity_err, 1);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
